// File: rtl/big_sm_ddr3_cmd.sv
`default_nettype none
// ============================================================================
//  Module  : big_sm_ddr3_cmd
//  Brief   : DDR3 command sequencer FSM (init, ZQ, MRS, ACT/RD/WR/PRE/REF, PD/SR).
//            Optional debug port State_out enabled by BIGSM_STATE_PORT_EN.
//  Revision: 1.0 - initial release
// ============================================================================
module big_sm_ddr3_cmd #(
   parameter int T_RFC = 8,
   parameter int T_RCD = 2,
   parameter int BL    = 4,
   parameter int T_CL  = 3
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        ZQCL,
   input  logic        MRS,
   input  logic        REF,
   input  logic        SRE,
   input  logic        SRX,
   input  logic        PDE,
   input  logic        PDX,
   input  logic        CKE,
   input  logic        ACT,
   input  logic        PRE,
   input  logic        READ,
   input  logic        WRITE,
   input  logic        READ_AP,
   input  logic        WRITE_AP,
   input  logic [2:0]  BA_in,
   input  logic [14:0] Addr_Row,
   input  logic [9:0]  Addr_Column,
   input  logic        Addr_Column_11,
   input  logic        A_10,
   input  logic        A_12,
   input  logic [15:0] DQ_in,
   output logic        CS,
   output logic        RAS,
   output logic        CAS,
   output logic        WE,
   output logic [14:0] Addr_out,
   output logic [2:0]  BA_out,
   output logic        LDM,
   output logic        UDM,
   output logic [15:0] DQ_out,
   output logic        LDQS,
   output logic        UDQS
`ifdef BIGSM_STATE_PORT_EN
   ,
   output logic [4:0]  State_out
`endif
);

   typedef enum logic [4:0] {
      S_POWER_UP       = 5'd0,
      S_RESET_PROC     = 5'd1,
      S_INIT           = 5'd2,
      S_ZQ_CAL         = 5'd3,
      S_IDLE           = 5'd4,
      S_WRITE_LEVELING = 5'd5,
      S_REFRESHING     = 5'd6,
      S_SELF_REFRESH   = 5'd7,
      S_PRE_PD         = 5'd8,
      S_ACTIVATING     = 5'd9,
      S_BANK_ACTIVE    = 5'd10,
      S_WRITING        = 5'd11,
      S_READING        = 5'd12,
      S_WRITING_AP     = 5'd13,
      S_READING_AP     = 5'd14,
      S_PRECHARGING    = 5'd15,
      S_ACT_PD         = 5'd16
   } state_t;

   localparam logic [3:0] C_MRS  = 4'b0000;
   localparam logic [3:0] C_REF  = 4'b0001;
   localparam logic [3:0] C_PRE  = 4'b0010;
   localparam logic [3:0] C_ACT  = 4'b0011;
   localparam logic [3:0] C_WR   = 4'b0100;
   localparam logic [3:0] C_RD   = 4'b0101;
   localparam logic [3:0] C_ZQCL = 4'b0110;
   localparam logic [3:0] C_NOP  = 4'b0111;
   localparam logic [3:0] C_DES  = 4'b1111;

   // Last counter value of each timed state (counter is 0 in its first cycle)
   localparam logic [4:0] C_RFC_LAST = 5'(T_RFC - 1);
   localparam logic [4:0] C_RCD_LAST = 5'(T_RCD - 1);
   localparam logic [4:0] C_WR_LAST  = 5'(BL);
   localparam logic [4:0] C_RD_LAST  = 5'(T_CL + BL);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [4:0]  r_cnt;
   logic [4:0]  w_cnt_nxt;
   logic [3:0]  w_cmd;
   logic [14:0] w_addr;
   logic [2:0]  w_ba;
   logic [15:0] w_dq;
   logic        w_dqs;
   logic [14:0] w_col_addr;
   logic [14:0] w_col_addr_ap;

   assign w_col_addr    = {2'b00, A_12, Addr_Column_11, A_10, Addr_Column};
   assign w_col_addr_ap = {2'b00, A_12, Addr_Column_11, 1'b1, Addr_Column};

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = (r_cnt == 5'h1F) ? r_cnt : r_cnt + 5'd1;
      w_cmd       = C_NOP;
      w_addr      = '0;
      w_ba        = '0;
      w_dq        = '0;
      w_dqs       = 1'b0;
      case (r_state)
         S_POWER_UP:   w_state_nxt = S_RESET_PROC;
         S_RESET_PROC: w_state_nxt = S_INIT;
         S_INIT: begin
            if (ZQCL) begin
               w_state_nxt = S_ZQ_CAL;
               w_cmd       = C_ZQCL;
               w_addr      = 15'h0400;
            end
         end
         S_ZQ_CAL: begin
            if (!ZQCL) w_state_nxt = S_IDLE;
         end
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (MRS) begin
               w_state_nxt = S_WRITE_LEVELING;
               w_cmd       = C_MRS;
               w_addr      = Addr_Row;
               w_ba        = BA_in;
            end else if (REF) begin
               w_state_nxt = S_REFRESHING;
               w_cmd       = C_REF;
            end else if (SRE) begin
               w_state_nxt = S_SELF_REFRESH;
               w_cmd       = C_REF;
            end else if (PDE) begin
               w_state_nxt = S_PRE_PD;
               w_cmd       = C_DES;
            end else if (ACT) begin
               w_state_nxt = S_ACTIVATING;
               w_cmd       = C_ACT;
               w_addr      = Addr_Row;
               w_ba        = BA_in;
            end
         end
         S_WRITE_LEVELING: begin
            if (!MRS) w_state_nxt = S_IDLE;
         end
         S_REFRESHING: begin
            if (r_cnt == C_RFC_LAST) w_state_nxt = S_IDLE;
         end
         S_SELF_REFRESH: begin
            if (SRX || CKE) w_state_nxt = S_IDLE;
            else            w_cmd       = C_DES;
         end
         S_PRE_PD: begin
            if (PDX || CKE) w_state_nxt = S_IDLE;
            else            w_cmd       = C_DES;
         end
         S_ACTIVATING: begin
            if (r_cnt == C_RCD_LAST) w_state_nxt = S_BANK_ACTIVE;
         end
         S_BANK_ACTIVE: begin
            w_cnt_nxt = '0;
            w_ba      = BA_in;
            if (PRE) begin
               w_state_nxt = S_PRECHARGING;
               w_cmd       = C_PRE;
               w_addr      = {4'b0000, A_10, 10'b0};
            end else if (WRITE_AP) begin
               w_state_nxt = S_WRITING_AP;
               w_cmd       = C_WR;
               w_addr      = w_col_addr_ap;
            end else if (READ_AP) begin
               w_state_nxt = S_READING_AP;
               w_cmd       = C_RD;
               w_addr      = w_col_addr_ap;
            end else if (WRITE) begin
               w_state_nxt = S_WRITING;
               w_cmd       = C_WR;
               w_addr      = w_col_addr;
            end else if (READ) begin
               w_state_nxt = S_READING;
               w_cmd       = C_RD;
               w_addr      = w_col_addr;
            end else if (PDE) begin
               w_state_nxt = S_ACT_PD;
               w_cmd       = C_DES;
               w_ba        = '0;
            end else begin
               w_ba        = '0;
            end
         end
         S_WRITING, S_WRITING_AP: begin
            // Beat k is launched while the counter holds k; strobe starts high
            if (r_cnt < C_WR_LAST) begin
               w_dq  = DQ_in;
               w_dqs = ~r_cnt[0];
            end else begin
               w_state_nxt = (r_state == S_WRITING) ? S_BANK_ACTIVE : S_IDLE;
            end
         end
         S_READING, S_READING_AP: begin
            if (r_cnt == C_RD_LAST)
               w_state_nxt = (r_state == S_READING) ? S_BANK_ACTIVE : S_IDLE;
         end
         S_PRECHARGING: w_state_nxt = S_IDLE;
         S_ACT_PD: begin
            if (PDX || CKE) w_state_nxt = S_BANK_ACTIVE;
            else            w_cmd       = C_DES;
         end
         default: w_state_nxt = S_POWER_UP;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state  <= S_POWER_UP;
         r_cnt    <= '0;
         CS       <= 1'b1;
         RAS      <= 1'b1;
         CAS      <= 1'b1;
         WE       <= 1'b1;
         Addr_out <= '0;
         BA_out   <= '0;
         DQ_out   <= '0;
         LDQS     <= 1'b0;
         UDQS     <= 1'b0;
         LDM      <= 1'b0;
         UDM      <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         {CS, RAS, CAS, WE} <= w_cmd;
         Addr_out <= w_addr;
         BA_out   <= w_ba;
         DQ_out   <= w_dq;
         LDQS     <= w_dqs;
         UDQS     <= w_dqs;
         LDM      <= 1'b0;
         UDM      <= 1'b0;
      end
   end

`ifdef BIGSM_STATE_PORT_EN
   assign State_out = r_state;
`endif

endmodule
`default_nettype wire

// File: tb/tb_big_sm_ddr3_cmd.sv
`default_nettype none
// ============================================================================
//  Module  : tb_big_sm_ddr3_cmd
//  Brief   : Directed vector table, hand sequences and random stimulus against
//            a cycle-schedule reference model of the DDR3 command sequencer.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_big_sm_ddr3_cmd;

   localparam int T_RFC = 8;
   localparam int T_RCD = 2;
   localparam int BL    = 4;
   localparam int T_CL  = 3;

   localparam logic [15:0] Q_ZQ   = 16'h0001;
   localparam logic [15:0] Q_MRS  = 16'h0002;
   localparam logic [15:0] Q_REF  = 16'h0004;
   localparam logic [15:0] Q_SRE  = 16'h0008;
   localparam logic [15:0] Q_SRX  = 16'h0010;
   localparam logic [15:0] Q_ACT  = 16'h0100;
   localparam logic [15:0] Q_PRE  = 16'h0200;
   localparam logic [15:0] Q_WR   = 16'h0800;
   localparam logic [15:0] Q_RDAP = 16'h1000;

   localparam int P_INIT = 0, P_ZQ = 1, P_IDLE = 2, P_WL = 3, P_SR = 4,
                  P_PD = 5, P_BANK = 6, P_APD = 7;

   logic CLK, RESET, ZQCL, MRS, REF, SRE, SRX, PDE, PDX, CKE;
   logic ACT, PRE, READ, WRITE, READ_AP, WRITE_AP;
   logic [2:0]  BA_in;
   logic [14:0] Addr_Row;
   logic [9:0]  Addr_Column;
   logic        Addr_Column_11, A_10, A_12;
   logic [15:0] DQ_in;
   wire         CS, RAS, CAS, WE, LDM, UDM, LDQS, UDQS;
   wire  [14:0] Addr_out;
   wire  [2:0]  BA_out;
   wire  [15:0] DQ_out;

   big_sm_ddr3_cmd #(.T_RFC(T_RFC), .T_RCD(T_RCD), .BL(BL), .T_CL(T_CL)) dut (
      .CLK(CLK), .RESET(RESET), .ZQCL(ZQCL), .MRS(MRS), .REF(REF), .SRE(SRE),
      .SRX(SRX), .PDE(PDE), .PDX(PDX), .CKE(CKE), .ACT(ACT), .PRE(PRE),
      .READ(READ), .WRITE(WRITE), .READ_AP(READ_AP), .WRITE_AP(WRITE_AP),
      .BA_in(BA_in), .Addr_Row(Addr_Row), .Addr_Column(Addr_Column),
      .Addr_Column_11(Addr_Column_11), .A_10(A_10), .A_12(A_12), .DQ_in(DQ_in),
      .CS(CS), .RAS(RAS), .CAS(CAS), .WE(WE), .Addr_out(Addr_out),
      .BA_out(BA_out), .LDM(LDM), .UDM(UDM), .DQ_out(DQ_out),
      .LDQS(LDQS), .UDQS(UDQS)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   wire [41:0] w_got = {CS, RAS, CAS, WE, Addr_out, BA_out, DQ_out, LDQS, UDQS, LDM, UDM};

   function automatic logic [41:0] pk(logic [3:0] c, logic [14:0] a, logic [2:0] b,
                                      logic [15:0] d, logic s);
      return {c, a, b, d, s, s, 2'b00};
   endfunction

   localparam logic [41:0] RST_V = {4'hF, 15'h0, 3'h0, 16'h0, 4'h0};
   logic [41:0] NOP_V, DES_V;

   int total = 0;
   int bad   = 0;

   task automatic check(string name, logic [41:0] e);
      total++;
      if (w_got !== e) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, w_got, e);
      end
   endtask

   // Reference model: command issue plus a fixed busy schedule per command
   int          m_phase, m_busy, m_after, m_beat;
   bit          m_wr;
   logic [41:0] exp_v;

   task automatic model_reset();
      m_busy = 2; m_after = P_INIT; m_wr = 0; m_beat = 0; m_phase = P_INIT;
   endtask

   task automatic sched(int cycles, int after, bit wr);
      m_busy = cycles; m_after = after; m_wr = wr; m_beat = 0;
   endtask

   function automatic logic [14:0] col(logic ap);
      return {2'b00, A_12, Addr_Column_11, ap, Addr_Column};
   endfunction

   task automatic model_eval();
      exp_v = NOP_V;
      if (m_busy > 0) begin
         if (m_wr && m_beat < BL) begin
            exp_v = pk(4'h7, 15'h0, 3'h0, DQ_in, (m_beat % 2) == 0);
            m_beat++;
         end
         m_busy--;
         if (m_busy == 0) m_phase = m_after;
      end else begin
         case (m_phase)
            P_INIT: if (ZQCL) begin exp_v = pk(4'h6, 15'h0400, 3'h0, 16'h0, 1'b0); m_phase = P_ZQ; end
            P_ZQ:   if (!ZQCL) m_phase = P_IDLE;
            P_IDLE: begin
               if (MRS) begin
                  exp_v = pk(4'h0, Addr_Row, BA_in, 16'h0, 1'b0); m_phase = P_WL;
               end else if (REF) begin
                  exp_v = pk(4'h1, 15'h0, 3'h0, 16'h0, 1'b0); sched(T_RFC, P_IDLE, 0);
               end else if (SRE) begin
                  exp_v = pk(4'h1, 15'h0, 3'h0, 16'h0, 1'b0); m_phase = P_SR;
               end else if (PDE) begin
                  exp_v = DES_V; m_phase = P_PD;
               end else if (ACT) begin
                  exp_v = pk(4'h3, Addr_Row, BA_in, 16'h0, 1'b0); sched(T_RCD, P_BANK, 0);
               end
            end
            P_WL:   if (!MRS) m_phase = P_IDLE;
            P_SR:   if (SRX || CKE) m_phase = P_IDLE; else exp_v = DES_V;
            P_PD:   if (PDX || CKE) m_phase = P_IDLE; else exp_v = DES_V;
            P_BANK: begin
               if (PRE) begin
                  exp_v = pk(4'h2, {4'h0, A_10, 10'h0}, BA_in, 16'h0, 1'b0); sched(1, P_IDLE, 0);
               end else if (WRITE_AP) begin
                  exp_v = pk(4'h4, col(1'b1), BA_in, 16'h0, 1'b0); sched(BL + 1, P_IDLE, 1);
               end else if (READ_AP) begin
                  exp_v = pk(4'h5, col(1'b1), BA_in, 16'h0, 1'b0); sched(1 + T_CL + BL, P_IDLE, 0);
               end else if (WRITE) begin
                  exp_v = pk(4'h4, col(A_10), BA_in, 16'h0, 1'b0); sched(BL + 1, P_BANK, 1);
               end else if (READ) begin
                  exp_v = pk(4'h5, col(A_10), BA_in, 16'h0, 1'b0); sched(1 + T_CL + BL, P_BANK, 0);
               end else if (PDE) begin
                  exp_v = DES_V; m_phase = P_APD;
               end
            end
            P_APD:  if (PDX || CKE) m_phase = P_BANK; else exp_v = DES_V;
            default: m_phase = P_INIT;
         endcase
      end
   endtask

   task automatic drive(logic [15:0] q, logic [2:0] ba, logic [14:0] row,
                        logic [9:0] c, logic c11, logic [15:0] dq);
      ZQCL = q[0];  MRS = q[1];   REF = q[2];   SRE = q[3];
      SRX = q[4];   PDE = q[5];   PDX = q[6];   CKE = q[7];
      ACT = q[8];   PRE = q[9];   READ = q[10]; WRITE = q[11];
      READ_AP = q[12]; WRITE_AP = q[13]; A_10 = q[14]; A_12 = q[15];
      BA_in = ba; Addr_Row = row; Addr_Column = c; Addr_Column_11 = c11; DQ_in = dq;
   endtask

   task automatic step();
      model_eval();
      @(posedge CLK);
      #1;
      check("model", exp_v);
   endtask

   typedef struct {
      int          n;
      logic [15:0] req;
      logic [2:0]  ba;
      logic [14:0] row;
      logic [9:0]  c;
      logic [15:0] dq;
      logic [41:0] e;
      string       name;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(int n, logic [15:0] q, logic [2:0] ba, logic [14:0] row,
                               logic [9:0] c, logic [15:0] dq, logic [41:0] e, string name);
      vec_t v;
      v.n = n; v.req = q; v.ba = ba; v.row = row; v.c = c; v.dq = dq; v.e = e; v.name = name;
      return v;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] q;
      NOP_V = pk(4'h7, 15'h0, 3'h0, 16'h0, 1'b0);
      DES_V = pk(4'hF, 15'h0, 3'h0, 16'h0, 1'b0);

      tbl.push_back(mk(3, 16'h0, 3'd0, 15'h0, 10'h0, 16'h0, NOP_V, "pwrup"));
      tbl.push_back(mk(1, Q_ZQ, 3'd0, 15'h0, 10'h0, 16'h0, pk(4'h6, 15'h0400, 3'd0, 16'h0, 1'b0), "zq_cmd"));
      tbl.push_back(mk(1, Q_ZQ, 3'd0, 15'h0, 10'h0, 16'h0, NOP_V, "zq_hold"));
      tbl.push_back(mk(1, 16'h0, 3'd0, 15'h0, 10'h0, 16'h0, NOP_V, "zq_exit"));
      tbl.push_back(mk(1, Q_MRS, 3'd1, 15'h0123, 10'h0, 16'h0, pk(4'h0, 15'h0123, 3'd1, 16'h0, 1'b0), "mrs_cmd"));
      tbl.push_back(mk(1, Q_MRS, 3'd1, 15'h0123, 10'h0, 16'h0, NOP_V, "mrs_hold"));
      tbl.push_back(mk(1, 16'h0, 3'd0, 15'h0, 10'h0, 16'h0, NOP_V, "mrs_exit"));
      tbl.push_back(mk(1, Q_REF, 3'd0, 15'h0, 10'h0, 16'h0, pk(4'h1, 15'h0, 3'd0, 16'h0, 1'b0), "ref_cmd"));
      tbl.push_back(mk(1, Q_REF, 3'd0, 15'h0, 10'h0, 16'h0, NOP_V, "ref_once"));
      tbl.push_back(mk(5, 16'h0, 3'd0, 15'h0, 10'h0, 16'h0, NOP_V, "ref_wait"));
      tbl.push_back(mk(2, Q_ACT, 3'd2, 15'h5D6E, 10'h0, 16'h0, NOP_V, "ref_busy"));
      tbl.push_back(mk(1, Q_ACT, 3'd2, 15'h5D6E, 10'h0, 16'h0, pk(4'h3, 15'h5D6E, 3'd2, 16'h0, 1'b0), "act_cmd"));
      tbl.push_back(mk(2, Q_WR, 3'd2, 15'h0, 10'h3F8, 16'hA5A5, NOP_V, "rcd_wait"));
      tbl.push_back(mk(1, Q_WR, 3'd2, 15'h0, 10'h3F8, 16'hA5A5, pk(4'h4, 15'h03F8, 3'd2, 16'h0, 1'b0), "wr_cmd"));
      tbl.push_back(mk(1, 16'h0, 3'd0, 15'h0, 10'h0, 16'hA5A5, pk(4'h7, 15'h0, 3'd0, 16'hA5A5, 1'b1), "wr_b0"));
      tbl.push_back(mk(1, 16'h0, 3'd0, 15'h0, 10'h0, 16'hA5A5, pk(4'h7, 15'h0, 3'd0, 16'hA5A5, 1'b0), "wr_b1"));
      tbl.push_back(mk(1, 16'h0, 3'd0, 15'h0, 10'h0, 16'hA5A5, pk(4'h7, 15'h0, 3'd0, 16'hA5A5, 1'b1), "wr_b2"));
      tbl.push_back(mk(1, 16'h0, 3'd0, 15'h0, 10'h0, 16'hA5A5, pk(4'h7, 15'h0, 3'd0, 16'hA5A5, 1'b0), "wr_b3"));
      tbl.push_back(mk(1, Q_PRE, 3'd2, 15'h0, 10'h0, 16'h0, NOP_V, "wr_end"));
      tbl.push_back(mk(1, Q_PRE, 3'd2, 15'h0, 10'h0, 16'h0, pk(4'h2, 15'h0, 3'd2, 16'h0, 1'b0), "pre_cmd"));
      tbl.push_back(mk(1, 16'h0, 3'd0, 15'h0, 10'h0, 16'h0, NOP_V, "pre_exit"));
      tbl.push_back(mk(1, Q_ACT, 3'd5, 15'h0001, 10'h0, 16'h0, pk(4'h3, 15'h0001, 3'd5, 16'h0, 1'b0), "act2_cmd"));
      tbl.push_back(mk(2, 16'h0, 3'd0, 15'h0, 10'h0, 16'h0, NOP_V, "rcd2_wait"));
      tbl.push_back(mk(1, Q_RDAP, 3'd5, 15'h0, 10'h015, 16'h0, pk(4'h5, 15'h0415, 3'd5, 16'h0, 1'b0), "rdap_cmd"));
      tbl.push_back(mk(8, Q_PRE, 3'd5, 15'h0, 10'h0, 16'h0, NOP_V, "rdap_wait"));
      tbl.push_back(mk(1, Q_MRS, 3'd0, 15'h7FFF, 10'h0, 16'h0, pk(4'h0, 15'h7FFF, 3'd0, 16'h0, 1'b0), "rdap_idle"));
      tbl.push_back(mk(1, 16'h0, 3'd0, 15'h0, 10'h0, 16'h0, NOP_V, "mrs2_exit"));

      RESET = 1'b0;
      drive(16'h0, 3'd0, 15'h0, 10'h0, 1'b0, 16'h0);
      @(posedge CLK);
      #1;
      check("rst_init", RST_V);
      RESET = 1'b1;
      model_reset();

      for (int i = 0; i < tbl.size(); i++) begin
         for (int k = 0; k < tbl[i].n; k++) begin
            drive(tbl[i].req, tbl[i].ba, tbl[i].row, tbl[i].c, 1'b0, tbl[i].dq);
            step();
            check(tbl[i].name, tbl[i].e);
         end
      end

      // Self-refresh entry/exit, then a write aborted by reset mid-burst
      drive(Q_SRE, 3'd0, 15'h0, 10'h0, 1'b0, 16'h0); step(); check("sr_cmd", pk(4'h1, 15'h0, 3'd0, 16'h0, 1'b0));
      drive(16'h0, 3'd0, 15'h0, 10'h0, 1'b0, 16'h0); step(); check("sr_desel", DES_V);
      step(); check("sr_desel2", DES_V);
      drive(Q_SRX, 3'd0, 15'h0, 10'h0, 1'b0, 16'h0); step(); check("sr_exit", NOP_V);
      drive(Q_ACT, 3'd7, 15'h0ABC, 10'h0, 1'b0, 16'h0); step(); check("sr_act", pk(4'h3, 15'h0ABC, 3'd7, 16'h0, 1'b0));
      drive(16'h0, 3'd0, 15'h0, 10'h0, 1'b0, 16'h0); step(); step();
      drive(Q_WR, 3'd7, 15'h0, 10'h0AA, 1'b0, 16'h1234); step(); check("wr2_cmd", pk(4'h4, 15'h00AA, 3'd7, 16'h0, 1'b0));
      drive(16'h0, 3'd0, 15'h0, 10'h0, 1'b0, 16'h1234); step(); check("wr2_b0", pk(4'h7, 15'h0, 3'd0, 16'h1234, 1'b1));
      #2;
      RESET = 1'b0;
      #1;
      check("rst_async", RST_V);
      @(posedge CLK);
      #1;
      check("rst_hold", RST_V);
      RESET = 1'b1;
      model_reset();

      for (int i = 0; i < 3000; i++) begin
         q = 16'h0;
         for (int b = 0; b < 14; b++) q[b] = ($urandom_range(7) == 0);
         q[7]  = ($urandom_range(15) == 0);
         q[14] = 1'($urandom_range(1));
         q[15] = 1'($urandom_range(1));
         drive(q, 3'($urandom_range(7)), 15'($urandom), 10'($urandom), 1'($urandom_range(1)),
               16'($urandom));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
